level_diff_reader: RTL

LEVEL_DIFF_READER -- requirements
Module: level_diff_reader

---
 rtl/pyramid_pkg.sv | 6 +
 rtl/valid_addr_pipe.sv | 28 ++
 rtl/level_diff_reader.sv | 89 ++++++++
 3 files changed

// File: rtl/pyramid_pkg.sv
// pyramid_pkg: shared FSM state type and BRAM timing constants for pyramid level readers
package pyramid_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam int BRAM_LAT = 2;
  localparam int PIPE_DEPTH = BRAM_LAT + 1;
endpackage

// File: rtl/valid_addr_pipe.sv
// valid_addr_pipe: fixed-depth delay line carrying {valid, address} alongside the data path
module valid_addr_pipe #(
  parameter int AW = 12,
  parameter int DEPTH = 3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);
  logic [DEPTH-1:0] v;
  logic [AW-1:0] a [DEPTH];
  // shift valid and address one stage per cycle; reset clears every valid bit
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) a[i] <= '0;
    end else begin
      v <= DEPTH'({v, in_valid});
      a[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) a[i] <= a[i-1];
    end
  end
  assign out_valid = v[DEPTH-1];
  assign out_addr = a[DEPTH-1];
endmodule

// File: rtl/level_diff_reader.sv
// level_diff_reader: streams two pyramid levels and writes b - a per pixel (|b - a| when LEVEL_DIFF_ABS_EN is defined)
module level_diff_reader
  import pyramid_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int HEIGHT = 64,
  localparam int N = WIDTH * HEIGHT,
  localparam int AW = $clog2(N)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic [AW-1:0]        read_addr,
  output logic                 read_addr_valid,
  input  logic [BIT_DEPTH-1:0] pixel_a_in,
  input  logic [BIT_DEPTH-1:0] pixel_b_in,
  output logic [AW-1:0]        write_addr,
  output logic                 write_valid,
  output logic [BIT_DEPTH:0]   diff_out,
  output logic                 busy_out,
  output logic                 done_out
);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(PIPE_DEPTH - 1);
  state_t state;
  logic [1:0] drain_cnt;
  logic [BIT_DEPTH:0] diff_raw;
  logic [BIT_DEPTH:0] diff_next;
  // pass sequencer: issues every address once, then waits for the pipeline to empty
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      read_addr <= '0;
      read_addr_valid <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          state <= READ;
          read_addr <= '0;
          read_addr_valid <= 1'b1;
          busy_out <= 1'b1;
        end
        READ: if (read_addr == LAST) begin
          state <= DRAIN;
          read_addr_valid <= 1'b0;
          drain_cnt <= '0;
        end else begin
          read_addr <= read_addr + 1'b1;
        end
        DRAIN: if (drain_cnt == DRAIN_LAST) begin
          state <= DONE;
          done_out <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done_out <= 1'b0;
          busy_out <= 1'b0;
          read_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign diff_raw = {1'b0, pixel_b_in} - {1'b0, pixel_a_in};
`ifdef LEVEL_DIFF_ABS_EN
  assign diff_next = diff_raw[BIT_DEPTH] ? -diff_raw : diff_raw;
`else
  assign diff_next = diff_raw;
`endif
  // subtract register: BRAM data arrives aligned with pipe stage 2, result leaves with stage 3
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) diff_out <= '0;
    else diff_out <= diff_next;
  end
  valid_addr_pipe #(.AW(AW), .DEPTH(PIPE_DEPTH)) u_pipe (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .in_valid (read_addr_valid),
    .in_addr  (read_addr),
    .out_valid(write_valid),
    .out_addr (write_addr)
  );
endmodule
